// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the word-level serial pattern detector controller.
package seq_ctrl_pkg;

   // Controller phases: wait for a word, clock its bits, catch the last hit, hold the result.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int PAT_LEN   = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

endpackage : seq_ctrl_pkg

// File: rtl/pat_det4.sv
// Moore detector for a 4-bit serial pattern. The hit output depends only on registered
// history and fill level, so it reports the bit clocked in on the previous enabled edge.
module pat_det4
   import seq_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               en,
   input  logic               din,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               overlap,
   output logic               hit
);

   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [2:0]         fill_q, fill_d;

   // fill counts valid history bits; a non-overlapping hit restarts it so only the new bit counts
   assign hit = (fill_q == 3'(PAT_LEN)) && (hist_q == pattern);

   // Next history and fill level
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = {hist_q[PAT_LEN-2:0], din};
         if (hit && !overlap) begin
            fill_d = 3'd1;
         end else if (fill_q < 3'(PAT_LEN)) begin
            fill_d = fill_q + 3'd1;
         end
      end
   end

   // Detector state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule : pat_det4

// File: rtl/seq_det_ctrl.sv
// Word-level controller: accepts a word, shifts it MSB-first through pat_det4,
// counts and locates every detection, then holds the result until the consumer takes it.
module seq_det_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               overlap,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   match_count,
   output logic [WIDTH-1:0]   match_map,
   output logic               busy
);

   localparam int IDX_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [PAT_LEN-1:0] pattern_q, pattern_d;
   logic               overlap_q, overlap_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   map_q, map_d;

   logic               det_clear;
   logic               det_en;
   logic               det_din;
   logic               det_hit;

   pat_det4 u_det (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (det_clear),
      .en      (det_en),
      .din     (det_din),
      .pattern (pattern_q),
      .overlap (overlap_q),
      .hit     (det_hit)
   );

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == REPORT);
   assign busy        = (state_q == SHIFT) || (state_q == DRAIN);
   assign match_count = count_q;
   assign match_map   = map_q;
   assign det_din     = data_q[idx_q];

   // Next-state logic; a hit seen now belongs to the bit presented on the previous cycle (last_idx_q)
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_idx_d = last_idx_q;
      data_d     = data_q;
      pattern_d  = pattern_q;
      overlap_d  = overlap_q;
      count_d    = count_q;
      map_d      = map_q;
      det_clear  = 1'b0;
      det_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d    = in_data;
               pattern_d = pattern;
               overlap_d = overlap;
               count_d   = '0;
               map_d     = '0;
               idx_d     = IDX_W'(WIDTH - 1);
               det_clear = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            det_en     = 1'b1;
            last_idx_d = idx_q;
            // The first shift cycle follows a clear, so there is nothing to sample yet
            if (idx_q != IDX_W'(WIDTH - 1) && det_hit) begin
               if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
               map_d[last_idx_q] = 1'b1;
            end
            if (idx_q == '0) begin
               state_d = DRAIN;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DRAIN: begin
            if (det_hit) begin
               if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
               map_d[last_idx_q] = 1'b1;
            end
            state_d = REPORT;
         end
         REPORT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         last_idx_q <= '0;
         data_q     <= '0;
         pattern_q  <= '0;
         overlap_q  <= 1'b0;
         count_q    <= '0;
         map_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         data_q     <= data_d;
         pattern_q  <= pattern_d;
         overlap_q  <= overlap_d;
         count_q    <= count_d;
         map_q      <= map_d;
      end
   end

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a window-scan reference model predicts each word's
// result; two instances (CNT_W=4 and CNT_W=2) run in lockstep to cover counter saturation.
module tb_seq_det_ctrl;

   localparam int W       = 8;
   localparam int CMAX_A  = 15;
   localparam int CMAX_B  = 3;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic [3:0]   pattern;
   logic         overlap;
   logic         out_ready;

   logic         in_ready_a, out_valid_a, busy_a;
   logic [3:0]   match_count_a;
   logic [W-1:0] match_map_a;
   logic         in_ready_b, out_valid_b, busy_b;
   logic [1:0]   match_count_b;
   logic [W-1:0] match_map_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int           cnt_a;
      int           cnt_b;
      logic [W-1:0] map;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   seq_det_ctrl #(.WIDTH(W), .CNT_W(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .pattern(pattern), .overlap(overlap),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .match_count(match_count_a), .match_map(match_map_a), .busy(busy_a)
   );

   seq_det_ctrl #(.WIDTH(W), .CNT_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .pattern(pattern), .overlap(overlap),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .match_count(match_count_b), .match_map(match_map_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a match ends at bit idx when the 4-bit window d[idx+3:idx] equals the pattern
   // and at least 4 bits have been scanned since the word start (or since the last match when
   // detections must not overlap).
   function automatic void model(input logic [W-1:0] d, input logic [3:0] p, input logic ov,
                                 input int cmax, output int cnt, output logic [W-1:0] map);
      int run_start = 0;
      logic [W-1:0] win;
      cnt = 0;
      map = '0;
      for (int j = 0; j < W; j++) begin
         int idx = W - 1 - j;
         win = d >> idx;
         if ((j - run_start) >= 3 && win[3:0] == p) begin
            map[idx] = 1'b1;
            if (cnt < cmax) cnt++;
            if (!ov) run_start = j + 1;
         end
      end
   endfunction

   // Compare process: whenever a result is presented it must match the oldest prediction
   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid_a) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'(out_valid_a), 32'd0);
            end else begin
               chk("count_a", 32'(match_count_a), 32'(exp_q[0].cnt_a));
               chk("map_a",   32'(match_map_a),   32'(exp_q[0].map));
               chk("in_ready_in_report", 32'(in_ready_a), 32'd0);
               chk("out_valid_b", 32'(out_valid_b), 32'd1);
               chk("count_b", 32'(match_count_b), 32'(exp_q[0].cnt_b));
               chk("map_b",   32'(match_map_b),   32'(exp_q[0].map));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Present a word at the next edge; the prediction is queued when it is accepted
   task automatic start_word(input logic [W-1:0] d, input logic [3:0] p, input logic ov);
      exp_t e;
      int   c;
      int   waited = 0;
      while (!in_ready_a && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("in_ready_before_accept", 32'(in_ready_a), 32'd1);
      in_data  = d;
      pattern  = p;
      overlap  = ov;
      in_valid = 1'b1;
      model(d, p, ov, CMAX_A, c, e.map);
      e.cnt_a = c;
      model(d, p, ov, CMAX_B, c, e.map);
      e.cnt_b = c;
      exp_q.push_back(e);
      $display("[TB] word d=%b pat=%b ov=%0d -> exp count=%0d/%0d map=%b",
               d, p, ov, e.cnt_a, e.cnt_b, e.map);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble the inputs: the word in flight must use only the latched values
      in_data  = W'($urandom);
      pattern  = 4'($urandom);
      overlap  = 1'($urandom);
   endtask

   // Wait for the result (checking latency), hold it for 'hold' cycles, then take it
   task automatic finish_word(input int hold);
      int cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid_a && cyc < 40);
      chk("latency", 32'(cyc), 32'(W + 1));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;             // must be ignored while a result is pending
         in_data  = W'($urandom);
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(out_valid_a), 32'd1);
         chk("hold_in_ready",  32'(in_ready_a),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after_handshake", 32'(in_ready_a), 32'd1);
      chk("out_valid_after_handshake", 32'(out_valid_a), 32'd0);
   endtask

   initial begin
      int           c;
      logic [W-1:0] m;
      logic [W-1:0] d;
      reset_n   = 1'b0;
      in_valid  = 1'b1;   // handshake attempt during reset must be ignored
      in_data   = 8'hFF;
      pattern   = 4'hF;
      overlap   = 1'b1;
      out_ready = 1'b1;

      // Pin the reference model against hand-worked results
      model(8'hDA, 4'hD, 1'b1, CMAX_A, c, m); chk("pin_DA_ov1_cnt", 32'(c), 32'd2); chk("pin_DA_ov1_map", 32'(m), 32'h12);
      model(8'hDA, 4'hD, 1'b0, CMAX_A, c, m); chk("pin_DA_ov0_cnt", 32'(c), 32'd1); chk("pin_DA_ov0_map", 32'(m), 32'h10);
      model(8'hFF, 4'hF, 1'b1, CMAX_A, c, m); chk("pin_FF_ov1_cnt", 32'(c), 32'd5); chk("pin_FF_ov1_map", 32'(m), 32'h1F);
      model(8'hFF, 4'hF, 1'b0, CMAX_A, c, m); chk("pin_FF_ov0_cnt", 32'(c), 32'd2); chk("pin_FF_ov0_map", 32'(m), 32'h11);
      model(8'hFF, 4'hF, 1'b1, CMAX_B, c, m); chk("pin_FF_sat_cnt", 32'(c), 32'd3);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready_a),    32'd1);
      chk("rst_out_valid", 32'(out_valid_a),   32'd0);
      chk("rst_busy",      32'(busy_a),        32'd0);
      chk("rst_count",     32'(match_count_a), 32'd0);
      chk("rst_map",       32'(match_map_a),   32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset_n   = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 32'(busy_a), 32'd0);

      // Directed words from the test plan
      start_word(8'hDA, 4'hD, 1'b1); finish_word(0);
      start_word(8'hDA, 4'hD, 1'b0); finish_word(0);
      start_word(8'hFF, 4'hF, 1'b1); finish_word(0);
      start_word(8'hFF, 4'hF, 1'b0); finish_word(0);
      // Backpressure for 5 cycles, then back-to-back words
      start_word(8'hB6, 4'hB, 1'b1); finish_word(5);
      start_word(8'h6D, 4'h6, 1'b0); finish_word(0);
      start_word(8'hF0, 4'hE, 1'b1); finish_word(0);

      // Abort during the 4th shift cycle
      start_word(8'hE0, 4'hF, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_in_ready",  32'(in_ready_a),    32'd1);
      chk("abort_out_valid", 32'(out_valid_a),   32'd0);
      chk("abort_busy",      32'(busy_a),        32'd0);
      chk("abort_count",     32'(match_count_a), 32'd0);
      exp_q.delete();
      @(posedge clk); #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_no_report", 32'(out_valid_a), 32'd0);
      start_word(8'h80, 4'hF, 1'b1); finish_word(0);
      start_word(8'hF8, 4'hF, 1'b1); finish_word(1);

      // Randomized words, patterns often taken from the word so hits are common
      for (int k = 0; k < 40; k++) begin
         d = W'($urandom);
         if ($urandom_range(0, 1) == 1) pattern = 4'(d >> $urandom_range(0, 4));
         else                           pattern = 4'($urandom);
         start_word(d, pattern, 1'($urandom));
         finish_word($urandom_range(0, 3));
      end

      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_det_ctrl
